// File: rtl/branch_resolve_queue_pkg.sv
// rtl/branch_resolve_queue_pkg.sv - shared state encoding and default sizes for the branch resolve queue
package branch_resolve_queue_pkg;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RECOVER = 1'b1
   } brq_state_t;

   localparam int BRQ_AW    = 10;
   localparam int BRQ_DEPTH = 4;

endpackage

// File: rtl/brq_fifo.sv
// rtl/brq_fifo.sv - circular fall-through address FIFO with synchronous clear
module brq_fifo
   import branch_resolve_queue_pkg::*;
#(
   parameter int DEPTH = BRQ_DEPTH,
   parameter int AW    = BRQ_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_data,
   input  logic          rd_en,
   input  logic          clr,
   output logic [AW-1:0] head_data,
   output logic          full,
   output logic          empty
);

   // One extra pointer bit separates the full case from the empty case.
   localparam int PW = $clog2(DEPTH) + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [AW-1:0] mem [DEPTH];
   logic          do_rd;
   logic          do_wr;

   // Status flags and accepted read/write strobes; a pop frees a slot for a same-cycle push.
   always_comb begin
      empty     = (wr_ptr == rd_ptr);
      full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
      do_rd     = rd_en && !empty;
      do_wr     = wr_en && (!full || do_rd);
      head_data = mem[rd_ptr[PW-2:0]];
   end

   // Pointer update; clear drops every entry by catching the read pointer up.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         rd_ptr <= wr_ptr;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PW'(1);
         if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_wr && !clr) mem[wr_ptr[PW-2:0]] <= wr_data;
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - predicted-taken branch resolution queue with redirect/flush (optional BRANCH_STATS_EN counters)
module branch_resolve_queue
   import branch_resolve_queue_pkg::*;
#(
   parameter int DEPTH = BRQ_DEPTH,
   parameter int AW    = BRQ_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_valid,
   input  logic [AW-1:0] push_fall_addr,
   input  logic          res_valid,
   input  logic          res_taken,
   output logic          correct_en,
   output logic [AW-1:0] correction,
   output logic          flush,
   output logic          full,
   output logic          empty
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]   resolved_cnt,
   output logic [15:0]   mispredict_cnt
`endif
);

   brq_state_t    state;
   logic [AW-1:0] head_addr;
   logic          res_fire;
   logic          mispredict;
   logic          pop;
   logic          push;

   // Decode resolve/push events; nothing is accepted during the recovery cycle.
   always_comb begin
      res_fire   = (state == ST_RUN) && res_valid && !empty;
      mispredict = res_fire && !res_taken;
      pop        = res_fire && res_taken;
      push       = (state == ST_RUN) && push_valid && !mispredict;
   end

   brq_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (push),
      .wr_data   (push_fall_addr),
      .rd_en     (pop),
      .clr       (mispredict),
      .head_data (head_addr),
      .full      (full),
      .empty     (empty)
   );

   // Redirect FSM: a mispredict raises a one-cycle redirect/flush and spends one cycle in RECOVER.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_RUN;
         correct_en <= 1'b0;
         flush      <= 1'b0;
         correction <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               correct_en <= mispredict;
               flush      <= mispredict;
               if (mispredict) begin
                  correction <= head_addr;
                  state      <= ST_RECOVER;
               end
            end
            ST_RECOVER: begin
               correct_en <= 1'b0;
               flush      <= 1'b0;
               state      <= ST_RUN;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   // Free-running statistics counters; wrap naturally at 16 bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resolved_cnt   <= '0;
         mispredict_cnt <= '0;
      end else begin
         if (res_fire)   resolved_cnt   <= resolved_cnt + 16'd1;
         if (mispredict) mispredict_cnt <= mispredict_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - self-checking bench for branch_resolve_queue against a queue-based model
module tb_branch_resolve_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          push_valid;
   logic [AW-1:0] push_fall_addr;
   logic          res_valid;
   logic          res_taken;
   logic          correct_en;
   logic [AW-1:0] correction;
   logic          flush;
   logic          full;
   logic          empty;
`ifdef BRANCH_STATS_EN
   logic [15:0]   resolved_cnt;
   logic [15:0]   mispredict_cnt;
`endif

   branch_resolve_queue #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .push_valid     (push_valid),
      .push_fall_addr (push_fall_addr),
      .res_valid      (res_valid),
      .res_taken      (res_taken),
      .correct_en     (correct_en),
      .correction     (correction),
      .flush          (flush),
      .full           (full),
      .empty          (empty)
`ifdef BRANCH_STATS_EN
      ,
      .resolved_cnt   (resolved_cnt),
      .mispredict_cnt (mispredict_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of outstanding fall-through addresses.
   logic [AW-1:0] q[$];
   bit            m_rec  = 1'b0;
   bit            m_ce   = 1'b0;
   logic [AW-1:0] m_corr = '0;
   int            m_res  = 0;
   int            m_mis  = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_rec  = 1'b0;
         m_ce   = 1'b0;
         m_corr = '0;
         m_res  = 0;
         m_mis  = 0;
      end else if (m_rec) begin
         m_rec = 1'b0;
         m_ce  = 1'b0;
      end else begin
         m_ce = 1'b0;
         if (res_valid && q.size() > 0) begin
            m_res = (m_res + 1) % 65536;
            if (!res_taken) begin
               m_corr = q[0];
               m_ce   = 1'b1;
               m_rec  = 1'b1;
               m_mis  = (m_mis + 1) % 65536;
               q.delete();
            end else begin
               void'(q.pop_front());
            end
         end
         if (!m_rec && push_valid && q.size() < DEPTH) q.push_back(push_fall_addr);
      end
   end

   // Per-cycle comparison of every output against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("empty",      empty,      (q.size() == 0));
         check("full",       full,       (q.size() == DEPTH));
         check("correct_en", correct_en, m_ce);
         check("flush",      flush,      m_ce);
         check("correction", correction, m_corr);
`ifdef BRANCH_STATS_EN
         check("resolved_cnt",   resolved_cnt,   m_res);
         check("mispredict_cnt", mispredict_cnt, m_mis);
`endif
      end
   end

   task automatic cyc(input bit pv, input logic [AW-1:0] pa, input bit rv, input bit rt);
      @(negedge clk);
      push_valid     = pv;
      push_fall_addr = pa;
      res_valid      = rv;
      res_taken      = rt;
   endtask

   initial begin
      rst            = 1'b0;
      push_valid     = 1'b0;
      push_fall_addr = '0;
      res_valid      = 1'b0;
      res_taken      = 1'b0;
      repeat (3) @(negedge clk);
      rst    = 1'b1;
      chk_on = 1'b1;
      check("rst_empty", empty, 1);
      check("rst_full",  full, 0);
      check("rst_ce",    correct_en, 0);
      check("rst_corr",  correction, 0);
      check("rst_flush", flush, 0);

      // Correct prediction pops with no redirect
      cyc(1, 10'h005, 0, 0);
      cyc(0, 10'h000, 1, 1);
      cyc(0, 10'h000, 0, 0);
      check("t2_empty", empty, 1);
      check("t2_ce",    correct_en, 0);

      // Mispredict redirects to the oldest fall-through and flushes the queue
      cyc(1, 10'h005, 0, 0);
      cyc(1, 10'h00A, 0, 0);
      cyc(1, 10'h010, 0, 0);
      cyc(0, 10'h000, 1, 0);
      cyc(0, 10'h000, 0, 0);
      check("t3_ce",    correct_en, 1);
      check("t3_flush", flush, 1);
      check("t3_corr",  correction, 10'h005);
      check("t3_empty", empty, 1);
      cyc(0, 10'h000, 0, 0);
      check("t3_empty2", empty, 1);
      check("t3_ce2",    correct_en, 0);

      // Full, dropped push, pop+push while full, drain across the wrap
      cyc(1, 10'h001, 0, 0);
      cyc(1, 10'h002, 0, 0);
      cyc(1, 10'h003, 0, 0);
      cyc(1, 10'h004, 0, 0);
      cyc(0, 10'h000, 0, 0);
      check("t4_full", full, 1);
      cyc(1, 10'h055, 0, 0);
      cyc(1, 10'h3FF, 1, 1);
      cyc(0, 10'h000, 0, 0);
      check("t4_full2", full, 1);
      cyc(0, 10'h000, 1, 1);
      cyc(0, 10'h000, 1, 1);
      cyc(0, 10'h000, 1, 1);
      cyc(0, 10'h000, 1, 0);
      check("t4_full3",  full, 0);
      check("t4_empty3", empty, 0);
      // Inputs during the RECOVER cycle must be ignored
      cyc(1, 10'h111, 1, 0);
      check("t4_ce",   correct_en, 1);
      check("t4_corr", correction, 10'h3FF);
      cyc(0, 10'h000, 0, 0);
      check("t5_ce",    correct_en, 0);
      check("t5_empty", empty, 1);
      check("t5_hold",  correction, 10'h3FF);

      // Resolve on empty is ignored
      cyc(0, 10'h000, 1, 0);
      cyc(0, 10'h000, 0, 0);
      check("t6_ce",    correct_en, 0);
      check("t6_empty", empty, 1);
`ifdef BRANCH_STATS_EN
      check("t6_resolved",   resolved_cnt, 7);
      check("t6_mispredict", mispredict_cnt, 2);
`endif

      // Asynchronous reset during RECOVER drops the redirect at once
      cyc(1, 10'h0AA, 0, 0);
      cyc(0, 10'h000, 1, 0);
      cyc(0, 10'h000, 0, 0);
      check("t7_ce", correct_en, 1);
      #2 rst = 1'b0;
      #1;
      check("t7_ce_rst",    correct_en, 0);
      check("t7_flush_rst", flush, 0);
      check("t7_empty_rst", empty, 1);
      @(negedge clk);
      rst = 1'b1;

      // Randomized traffic including occasional pushes against full
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) < 55), AW'($urandom), ($urandom_range(0, 99) < 40),
             ($urandom_range(0, 99) < 75));
      end
      cyc(0, 10'h000, 0, 0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
